// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU issue/write-back sequencer.
// Holds the FSM encoding, opcode map, ALU codes, PSW bits and RC table.
package alu_sequencer_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_ILL  = 3'd4;

  localparam logic [3:0] FMT_ARITH = 4'b0100;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADDC  = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SUBC  = 4'h3;
  localparam logic [3:0] OP_DADD  = 4'h4;
  localparam logic [3:0] OP_CMP   = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_BIT   = 4'h9;
  localparam logic [3:0] OP_BIC   = 4'hA;
  localparam logic [3:0] OP_BIS   = 4'hB;
  localparam logic [3:0] OP_SHIFT = 4'hD;

  typedef enum logic [5:0] {
    ALU_ADD_W,  ALU_ADD_B,  ALU_ADDC_W, ALU_ADDC_B,
    ALU_SUB_W,  ALU_SUB_B,  ALU_SUBC_W, ALU_SUBC_B,
    ALU_DADD_W, ALU_DADD_B, ALU_CMP_W,  ALU_CMP_B,
    ALU_XOR_W,  ALU_XOR_B,  ALU_AND_W,  ALU_AND_B,
    ALU_OR_W,   ALU_OR_B,   ALU_BIT_W,  ALU_BIT_B,
    ALU_BIC_W,  ALU_BIC_B,  ALU_BIS_W,  ALU_BIS_B,
    ALU_SRA_W,  ALU_SRA_B,  ALU_RRC_W,  ALU_RRC_B
  } alu_code_e;

  localparam int PSW_V = 4;
  localparam int PSW_N = 2;
  localparam int PSW_Z = 1;
  localparam int PSW_C = 0;

  function automatic logic [15:0] rc_const(input logic [2:0] idx);
    logic [15:0] v;
    unique case (idx)
      3'd0:    v = 16'h0000;
      3'd1:    v = 16'h0001;
      3'd2:    v = 16'h0002;
      3'd3:    v = 16'h0004;
      3'd4:    v = 16'h0008;
      3'd5:    v = 16'h0010;
      3'd6:    v = 16'h0020;
      default: v = 16'hFFFF;
    endcase
    return v;
  endfunction

  function automatic logic is_legal(input logic [15:0] w);
    return (w[15:12] == FMT_ARITH) &&
           ((w[11:8] <= OP_BIS) ||
            ((w[11:8] == OP_SHIFT) && (w[5:4] == 2'b00)));
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of decode, register-file and ALU signals seen by the sequencer.
// master is the sequencer side, slave the surrounding datapath.
interface alu_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_raddr_a;
  logic [2:0]  rf_raddr_b;
  logic [15:0] rf_rdata_a;
  logic [15:0] rf_rdata_b;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [5:0]  alu_instr;
  logic        alu_opt;
  logic        alu_E;
  logic [15:0] alu_result;
  logic [15:0] alu_psw;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] psw;
  logic        psw_ld;
  logic [15:0] psw_ld_data;
  logic        done;
  logic        illegal;

  modport master (
    input  instr_valid, instr, rf_rdata_a, rf_rdata_b,
    input  alu_result, alu_psw, psw_ld, psw_ld_data,
    output instr_ready, rf_raddr_a, rf_raddr_b,
    output alu_op1, alu_op2, alu_instr, alu_opt, alu_E,
    output rf_we, rf_waddr, rf_wdata, psw, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_rdata_a, rf_rdata_b,
    output alu_result, alu_psw, psw_ld, psw_ld_data,
    input  instr_ready, rf_raddr_a, rf_raddr_b,
    input  alu_op1, alu_op2, alu_instr, alu_opt, alu_E,
    input  rf_we, rf_waddr, rf_wdata, psw, done, illegal
  );
endinterface

// File: rtl/alu_sequencer_decode.sv
// Combinational decode of the latched instruction into ALU controls.
// ir[2:0] is the destination and is consumed by the top directly.
module alu_sequencer_decode
  import alu_sequencer_pkg::*;
(
  input  logic [15:3] ir,
  output logic        legal,
  output logic [5:0]  alu_instr,
  output logic        use_const,
  output logic [15:0] const_val,
  output logic        wb_en
);

  logic fmt_ok;
  logic is_arith;
  logic is_shift;

  assign fmt_ok   = (ir[15:12] == FMT_ARITH);
  assign is_arith = fmt_ok && (ir[11:8] <= OP_BIS);
  assign is_shift = fmt_ok && (ir[11:8] == OP_SHIFT) &&
                    (ir[5:4] == 2'b00);

  always_comb begin
    legal     = 1'b0;
    alu_instr = '0;
    use_const = ir[7];
    const_val = rc_const(ir[5:3]);
    wb_en     = 1'b0;
    unique case (1'b1)
      is_arith: begin
        legal     = 1'b1;
        alu_instr = {ir[11:8], ir[6]};
        wb_en     = !((ir[11:8] == OP_CMP) ||
                      (ir[11:8] == OP_BIT));
      end
      is_shift: begin
        // single-operand shifts see a zero source operand
        legal     = 1'b1;
        alu_instr = ALU_SRA_W | {4'b0000, ir[3], ir[6]};
        use_const = 1'b1;
        const_val = '0;
        wb_en     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-cycle issue/write-back controller: READ, EXEC, WB per instruction.
// Operands and ALU outputs are captured once each; psw_ld wins over WB.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.master bus
);

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] res_q, res_d;
  logic [15:0] npsw_q, npsw_d;
  logic [15:0] psw_q, psw_d;

  logic        dec_legal;
  logic [5:0]  dec_instr;
  logic        dec_use_const;
  logic [15:0] dec_const;
  logic        dec_wb_en;
  logic        wb_fire;

  alu_sequencer_decode u_decode (
    .ir        (ir_q[15:3]),
    .legal     (dec_legal),
    .alu_instr (dec_instr),
    .use_const (dec_use_const),
    .const_val (dec_const),
    .wb_en     (dec_wb_en)
  );

  assign wb_fire = (state_q == S_WB) && dec_legal;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    src_d   = src_q;
    dst_d   = dst_q;
    res_d   = res_q;
    npsw_d  = npsw_q;
    psw_d   = psw_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = is_legal(bus.instr) ? S_READ : S_ILL;
        end
      end
      S_READ: begin
        src_d   = bus.rf_rdata_a;
        dst_d   = bus.rf_rdata_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = bus.alu_result;
        npsw_d  = bus.alu_psw;
        state_d = S_WB;
      end
      S_WB: begin
        if (wb_fire) psw_d = npsw_q;
        state_d = S_IDLE;
      end
      S_ILL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.psw_ld) psw_d = bus.psw_ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      res_q   <= '0;
      npsw_q  <= '0;
      psw_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      res_q   <= res_d;
      npsw_q  <= npsw_d;
      psw_q   <= psw_d;
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.rf_raddr_a  = ir_q[5:3];
  assign bus.rf_raddr_b  = ir_q[2:0];
  assign bus.alu_op1     = dst_q;
  assign bus.alu_op2     = dec_use_const ? dec_const : src_q;
  assign bus.alu_instr   = dec_instr;
  assign bus.alu_opt     = 1'b1;
  assign bus.alu_E       = (state_q == S_EXEC);
  assign bus.rf_we       = wb_fire && dec_wb_en;
  assign bus.rf_waddr    = ir_q[2:0];
  assign bus.rf_wdata    = res_q;
  assign bus.psw         = psw_q;
  assign bus.done        = (state_q == S_WB);
  assign bus.illegal     = (state_q == S_ILL);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer with its own
// register file, behavioural ALU and architectural reference model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int failed = 0;

  logic [15:0] rf [8];
  logic        bd_we;
  logic [2:0]  bd_addr;
  logic [15:0] bd_data;
  logic [15:0] mregs [8];
  logic [15:0] mpsw;
  logic [15:0] kt [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0004,
                          16'h0008, 16'h0010, 16'h0020, 16'hFFFF};

  // Behavioural ALU: op1 is the destination, op2 the source.
  function automatic logic [31:0] alu_ref(
    input logic [5:0] code, input logic [15:0] a,
    input logic [15:0] b, input logic [15:0] pin);
    int msk, msb, x, y, c, r, d, cy, op;
    logic cf, vf;
    logic [15:0] res, po;
    msk = code[0] ? 'hFF : 'hFFFF;
    msb = code[0] ? 'h80 : 'h8000;
    x = int'(a) & msk;
    y = int'(b) & msk;
    c = pin[0] ? 1 : 0;
    op = int'(code[5:1]);
    cf = 1'b0; vf = 1'b0; r = 0;
    case (op)
      0, 1: begin
        r = x + y + ((op == 1) ? c : 0);
        cf = (r > msk);
        vf = (((x ^ r) & (y ^ r) & msb) != 0);
      end
      2, 3, 5: begin
        r = x - y - ((op == 3) ? c : 0);
        cf = (r < 0);
        vf = (((x ^ y) & (x ^ r) & msb) != 0);
      end
      4: begin
        cy = c;
        for (int i = 0; i < (code[0] ? 2 : 4); i++) begin
          d = ((x >> (4 * i)) & 15) + ((y >> (4 * i)) & 15) + cy;
          if (d > 9) begin d = d + 6; cy = 1; end
          else cy = 0;
          r = r | ((d & 15) << (4 * i));
        end
        cf = (cy != 0);
      end
      6:     r = x ^ y;
      7, 9:  r = x & y;
      8, 11: r = x | y;
      10:    r = x & ~y;
      12: begin r = (x >> 1) | (x & msb); cf = ((x & 1) != 0); end
      13: begin r = (x >> 1) | ((c != 0) ? msb : 0); cf = ((x & 1) != 0); end
      default: r = 0;
    endcase
    r = r & msk;
    res = code[0] ? ((a & 16'hFF00) | 16'(r)) : 16'(r);
    po = pin & 16'hFFE8;
    po[4] = vf;
    po[2] = ((r & msb) != 0);
    po[1] = (r == 0);
    po[0] = cf;
    return {po, res};
  endfunction

  function automatic logic legal_ref(input logic [15:0] w);
    if (w[15:12] != 4'd4) return 1'b0;
    if (w[11:8] < 4'd12) return 1'b1;
    return (w[11:8] == 4'd13) && (w[5:4] == 2'd0);
  endfunction

  always @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    else if (bd_we) rf[bd_addr] <= bd_data;
  end

  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

  always_comb begin
    {bus.alu_psw, bus.alu_result} = 32'hDEAD_BEEF;
    if (bus.alu_E)
      {bus.alu_psw, bus.alu_result} =
        alu_ref(bus.alu_instr, bus.alu_op1, bus.alu_op2, bus.psw);
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int i, input logic [15:0] v);
    bd_we = 1'b1;
    bd_addr = 3'(i);
    bd_data = v;
    @(negedge clk);
    bd_we = 1'b0;
    mregs[i] = v;
  endtask

  task automatic load_psw(input logic [15:0] v);
    bus.psw_ld = 1'b1;
    bus.psw_ld_data = v;
    @(negedge clk);
    bus.psw_ld = 1'b0;
    chk("psw_ld", bus.psw, v);
    mpsw = v;
  endtask

  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready", 16'(bus.instr_ready), 16'd1);
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr = 16'($urandom);
  endtask

  task automatic run_legal(input logic [15:0] ins, input logic ld,
                           input logic [15:0] ldv);
    logic [2:0] s, dd;
    logic [5:0] code;
    logic [15:0] o1, o2, er, ep;
    logic [31:0] pr;
    logic wb;
    s = ins[5:3];
    dd = ins[2:0];
    if (ins[11:8] == 4'hD) begin
      code = 6'd24 + (ins[3] ? 6'd2 : 6'd0) + (ins[6] ? 6'd1 : 6'd0);
      o2 = 16'h0000;
    end else begin
      code = {ins[11:8], ins[6]};
      o2 = ins[7] ? kt[s] : mregs[s];
    end
    o1 = mregs[dd];
    pr = alu_ref(code, o1, o2, mpsw);
    er = pr[15:0];
    ep = pr[31:16];
    wb = (ins[11:8] != 4'h5) && (ins[11:8] != 4'h9);
    issue(ins);
    chk("read_busy", 16'(bus.instr_ready), 16'd0);
    chk("raddr_a", 16'(bus.rf_raddr_a), 16'(s));
    chk("raddr_b", 16'(bus.rf_raddr_b), 16'(dd));
    @(negedge clk);
    chk("exec_E", 16'(bus.alu_E), 16'd1);
    chk("alu_instr", 16'(bus.alu_instr), 16'(code));
    chk("op1", bus.alu_op1, o1);
    chk("op2", bus.alu_op2, o2);
    chk("opt", 16'(bus.alu_opt), 16'd1);
    @(negedge clk);
    chk("wb_done", 16'(bus.done), 16'd1);
    chk("wb_we", 16'(bus.rf_we), 16'(wb));
    chk("waddr", 16'(bus.rf_waddr), 16'(dd));
    chk("wdata", bus.rf_wdata, er);
    if (ld) begin
      bus.psw_ld = 1'b1;
      bus.psw_ld_data = ldv;
    end
    @(negedge clk);
    bus.psw_ld = 1'b0;
    mpsw = ld ? ldv : ep;
    if (wb) mregs[dd] = er;
    chk("psw", bus.psw, mpsw);
    chk("idle_ready", 16'(bus.instr_ready), 16'd1);
    chk("done_low", 16'(bus.done), 16'd0);
    chk("rf", rf[dd], mregs[dd]);
  endtask

  task automatic run_illegal(input logic [15:0] ins);
    issue(ins);
    chk("ill_pulse", 16'(bus.illegal), 16'd1);
    chk("ill_we", 16'(bus.rf_we), 16'd0);
    chk("ill_done", 16'(bus.done), 16'd0);
    @(negedge clk);
    chk("ill_ret", 16'(bus.instr_ready), 16'd1);
    chk("ill_low", 16'(bus.illegal), 16'd0);
    chk("ill_psw", bus.psw, mpsw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    bus.psw_ld = 1'b0;
    bus.psw_ld_data = 16'h0000;
    bd_we = 1'b0;
    bd_addr = 3'd0;
    bd_data = 16'h0000;
    mpsw = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", 16'(bus.instr_ready), 16'd1);
    chk("rst_we", 16'(bus.rf_we), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_ill", 16'(bus.illegal), 16'd0);
    chk("rst_E", 16'(bus.alu_E), 16'd0);
    chk("rst_psw", bus.psw, 16'h0000);
    chk("rst_raddr", 16'({bus.rf_raddr_a, bus.rf_raddr_b}), 16'd0);
    chk("rst_waddr", 16'(bus.rf_waddr), 16'd0);
    chk("rst_wdata", bus.rf_wdata, 16'h0000);
    chk("rst_op1", bus.alu_op1, 16'h0000);
    chk("rst_op2", bus.alu_op2, 16'h0000);
    chk("rst_instr", 16'(bus.alu_instr), 16'd0);

    for (int i = 0; i < 8; i++) set_reg(i, 16'($urandom));

    set_reg(1, 16'h0005);
    set_reg(2, 16'h0003);
    run_legal(16'h400A, 1'b0, 16'h0);
    chk("add_rf", rf[2], 16'h0008);
    chk("add_psw", bus.psw, 16'h0000);

    set_reg(0, 16'h0001);
    run_legal(16'h4588, 1'b0, 16'h0);
    chk("cmp_psw", bus.psw, 16'h0002);
    chk("cmp_r0", rf[0], 16'h0001);

    set_reg(1, 16'h00FF);
    set_reg(2, 16'h1201);
    run_legal(16'h404A, 1'b0, 16'h0);
    chk("addb_rf", rf[2], 16'h1200);
    chk("addb_psw", bus.psw, 16'h0003);

    load_psw(16'h0001);
    set_reg(3, 16'h0001);
    run_legal(16'h4D0B, 1'b0, 16'h0);
    chk("rrc_rf", rf[3], 16'h8000);
    chk("rrc_c", 16'(bus.psw[0]), 16'd1);

    run_illegal(16'h6000);
    run_legal(16'h4631, 1'b0, 16'h0);

    load_psw(16'h0013);
    issue(16'h4225);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mpsw = 16'h0000;
    chk("rst_mid_ready", 16'(bus.instr_ready), 16'd1);
    chk("rst_mid_we", 16'(bus.rf_we), 16'd0);
    chk("rst_mid_done", 16'(bus.done), 16'd0);
    chk("rst_mid_psw", bus.psw, 16'h0000);
    @(negedge clk);
    chk("rst_mid_rf", rf[5], mregs[5]);

    run_legal(16'h4817, 1'b1, 16'h0116);

    for (int k = 0; k < 60; k++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 9) < 8) w[15:12] = 4'b0100;
      if ($urandom_range(0, 5) == 0) begin
        w[11:8] = 4'hD;
        if ($urandom_range(0, 3) != 0) w[5:4] = 2'b00;
      end
      if ($urandom_range(0, 7) == 0) load_psw(16'($urandom));
      if (legal_ref(w))
        run_legal(w, ($urandom_range(0, 9) == 0), 16'($urandom));
      else
        run_illegal(w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
